normalizer16_seq: RTL

- Multi-cycle normalizer that works in the opposite direction to the team's barrel shifter: given a data word, it finds the shift amount instead of applying one.
- dir=0: counts leading zeros and left-shifts until the MSB is 1. dir=1: counts trailing zeros and logically right-shifts until the LSB is 1.
- Outputs are the normalized word plus a 4-bit count, in the same s3..s0 encoding the barrel shifter consumes. Feeding the count back into the barrel shifter in the opposite direction restores the original word.
- Uses a binary-search datapath (stages of 8, 4, 2, 1 bits), one stage per clock, with valid/ready handshakes on both sides.

---
 rtl/normalizer16_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/normalizer16_seq.sv
`default_nettype none
// ============================================================================
//  Module   : normalizer16_seq
//  Purpose  : Sequential word normalizer. Finds the shift amount that makes
//             the MSB (dir=0, leading-zero count) or the LSB (dir=1,
//             trailing-zero count) of the word a 1, and returns the
//             normalized word with that count. A binary search is used: one
//             stage of 2^k bits (k = CW-1 .. 0) per clock. The count is in
//             s3..s0 form (cnt[k] = stage k shifted). Shifting o back by cnt
//             in the opposite direction restores the original word.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH : data width. Must be a power of two and at least 4 (default 16).
//    CW    : count width and number of search stages. Derived from WIDTH,
//            do not override.
//  Ports
//    clk       in   1      rising-edge clock
//    rst_n     in   1      synchronous active-low reset
//    in_valid  in   1      i/dir valid
//    in_ready  out  1      block idle and able to capture a word
//    i         in   WIDTH  word to normalize
//    dir       in   1      0 = leading-zero / left, 1 = trailing-zero / right
//    out_valid out  1      o/cnt/zero valid (held until out_ready)
//    out_ready in   1      downstream accepts the result
//    o         out  WIDTH  normalized word
//    cnt       out  CW     shift amount, cnt[k] = s_k
//    zero      out  1      input word was all zeros
//  Build option
//    NORM_EARLY_EXIT_EN : when defined, the search leaves SHIFT as soon as
//                         the word is already normalized (or zero). The
//                         result is identical, latency becomes 1..CW.
// ============================================================================
module normalizer16_seq #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i,
  input  logic             dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic [CW-1:0]    cnt,
  output logic             zero
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity check
  // --------------------------------------------------------------------------
  generate
    if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
      $error("normalizer16_seq: WIDTH must be a power of two and >= 4");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Search starts with the widest stage (WIDTH/2 bits).
  localparam logic [CW-1:0] K_FIRST = CW'(CW - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_data;   // working word being shifted by the search
  logic             r_dir;    // direction latched at capture
  logic [CW-1:0]    r_k;      // current stage index
  logic [CW-1:0]    r_cnt;    // accumulated count, also drives cnt
  logic             r_zero;   // captured word was all zeros
  logic [WIDTH-1:0] r_o;      // result word, loaded on entry to DONE

  // --------------------------------------------------------------------------
  // Stage datapath
  // --------------------------------------------------------------------------
  logic [CW:0]      w_step;     // 2^k, at most WIDTH/2
  logic [WIDTH-1:0] w_hi_mask;  // top `step` bits set
  logic [WIDTH-1:0] w_lo_mask;  // bottom `step` bits set
  logic             w_hit;      // examined field is all zero -> shift
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_last;     // stage 0 is being processed

  always_comb begin
    w_step     = (CW + 1)'(1) << r_k;
    // Variable-width part-selects are not legal, so the examined field is
    // isolated with a mask built from an all-ones word.
    w_hi_mask  = ~({WIDTH{1'b1}} >> w_step);
    w_lo_mask  = ~({WIDTH{1'b1}} << w_step);
    if (r_dir) begin
      w_hit     = ((r_data & w_lo_mask) == '0);
      w_shifted = r_data >> w_step;
    end else begin
      w_hit     = ((r_data & w_hi_mask) == '0);
      w_shifted = r_data << w_step;
    end
    w_data_nxt = w_hit ? w_shifted : r_data;
    w_last     = (r_k == '0);
  end

`ifdef NORM_EARLY_EXIT_EN
  // Word already has a 1 in the target end position; no more shifting
  // can change it, so the remaining count bits stay 0.
  logic w_norm;
  always_comb begin
    w_norm = r_dir ? r_data[0] : r_data[WIDTH-1];
  end
`endif

  // --------------------------------------------------------------------------
  // Control and datapath sequencing
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_dir   <= 1'b0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_o     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data  <= i;
            r_dir   <= dir;
            r_cnt   <= '0;
            r_k     <= K_FIRST;
            r_zero  <= (i == '0);
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
`ifdef NORM_EARLY_EXIT_EN
          if (w_norm || r_zero) begin
            // Exit before processing this stage. For a zero word the
            // count is still all zeros here, so only o needs forcing.
            r_o     <= r_zero ? '0 : r_data;
            r_state <= S_DONE;
          end else
`endif
          begin
            if (w_hit) begin
              r_data     <= w_shifted;
              r_cnt[r_k] <= 1'b1;
            end
            if (w_last) begin
              r_state <= S_DONE;
              if (r_zero) begin
                // A zero word "hits" every stage; the result is forced
                // to o=0, cnt=0. This later assignment overrides the
                // count bit written above.
                r_o   <= '0;
                r_cnt <= '0;
              end else begin
                r_o   <= w_data_nxt;
              end
            end else begin
              r_k <= r_k - CW'(1);
            end
          end
        end

        S_DONE: begin
          // Outputs keep their values after retirement.
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign o         = r_o;
  assign cnt       = r_cnt;
  assign zero      = r_zero;

endmodule
`default_nettype wire
